// File: rtl/adder_sb_pkg.sv
// Shared types and expected-value model for the adder scoreboard.
package adder_sb_pkg;

   localparam int unsigned SB_WIDTH = 8;
   localparam int unsigned SB_DEPTH = 4;

   typedef struct packed {
      logic [SB_WIDTH-1:0] a;
      logic [SB_WIDTH-1:0] b;
      logic                cin;
   } sb_entry_t;

   typedef struct packed {
      logic                cout;
      logic [SB_WIDTH-1:0] sum;
   } sb_result_t;

   // Full-width sum; the carry-out lands in the extra top bit.
   function automatic sb_result_t sb_expected(input sb_entry_t e);
      return sb_result_t'((SB_WIDTH+1)'(e.a) + (SB_WIDTH+1)'(e.b) + (SB_WIDTH+1)'(e.cin));
   endfunction

endpackage

// File: rtl/sb_fifo.sv
// Synchronous circular FIFO; pointers carry one extra wrap bit to tell full from empty.
module sb_fifo #(
   parameter int unsigned DW    = 17,
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic [DW-1:0]          wdata,
   output logic [DW-1:0]          rdata,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]   wptr;
   logic [AW:0]   rptr;
   logic [DW-1:0] mem [DEPTH];
   logic          do_push;
   logic          do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clock) begin
      if (reset) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + (AW+1)'(1);
         if (do_pop)  rptr <= rptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wptr[AW-1:0]] <= wdata;
   end

   assign rdata = mem[rptr[AW-1:0]];
   assign count = wptr - rptr;
   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/adder_scoreboard.sv
// Response-side scoreboard for the Adder: queues stimulus, compares results, counts outcomes.
// Optional macro ADDER_SB_FIRST_FAIL_EN adds a capture of the first mismatching transaction.
module adder_scoreboard
   import adder_sb_pkg::*;
#(
   parameter int unsigned WIDTH = SB_WIDTH,
   parameter int unsigned DEPTH = SB_DEPTH,
   parameter int unsigned CNT_W = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   io_stim_valid,
   output logic                   io_stim_ready,
   input  logic [WIDTH-1:0]       io_stim_A,
   input  logic [WIDTH-1:0]       io_stim_B,
   input  logic                   io_stim_Cin,
   input  logic                   io_rsp_valid,
   input  logic [WIDTH-1:0]       io_rsp_Sum,
   input  logic                   io_rsp_Cout,
   output logic [$clog2(DEPTH):0] io_pending,
   output logic [CNT_W-1:0]       io_pass_count,
   output logic [CNT_W-1:0]       io_fail_count,
   output logic                   io_underflow,
   output logic                   io_error
`ifdef ADDER_SB_FIRST_FAIL_EN
  ,output logic                   io_ff_valid,
   output logic [WIDTH-1:0]       io_ff_A,
   output logic [WIDTH-1:0]       io_ff_B,
   output logic                   io_ff_Cin,
   output logic [WIDTH-1:0]       io_ff_Sum,
   output logic                   io_ff_Cout
`endif
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   sb_entry_t  stim_entry;
   sb_entry_t  head_entry;
   sb_entry_t  stg_entry;
   sb_result_t stg_rsp;
   logic       stg_valid;
   logic       full;
   logic       empty;
   logic       pop;
   logic       mismatch;

   always_comb begin
      stim_entry     = '0;
      stim_entry.a   = SB_WIDTH'(io_stim_A);
      stim_entry.b   = SB_WIDTH'(io_stim_B);
      stim_entry.cin = io_stim_Cin;
   end

   // Pop decision uses pre-push state, so a push never satisfies a same-cycle response.
   assign pop = io_rsp_valid && !empty;

   sb_fifo #(
      .DW    ($bits(sb_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (io_stim_valid),
      .pop   (pop),
      .wdata (stim_entry),
      .rdata (head_entry),
      .count (io_pending),
      .full  (full),
      .empty (empty)
   );

   assign io_stim_ready = !full;

   // Compare stage payload; only meaningful while stg_valid is set.
   always_ff @(posedge clock) begin
      if (pop) begin
         stg_entry    <= head_entry;
         stg_rsp.sum  <= SB_WIDTH'(io_rsp_Sum);
         stg_rsp.cout <= io_rsp_Cout;
      end
   end

   assign mismatch = (stg_rsp != sb_expected(stg_entry));

   always_ff @(posedge clock) begin
      if (reset) begin
         stg_valid     <= 1'b0;
         io_pass_count <= '0;
         io_fail_count <= '0;
         io_underflow  <= 1'b0;
      end else begin
         stg_valid <= pop;
         if (io_rsp_valid && empty) io_underflow <= 1'b1;
         if (stg_valid) begin
            if (mismatch) begin
               if (io_fail_count != CNT_MAX) io_fail_count <= io_fail_count + CNT_W'(1);
            end else begin
               if (io_pass_count != CNT_MAX) io_pass_count <= io_pass_count + CNT_W'(1);
            end
         end
      end
   end

   assign io_error = (io_fail_count != '0) || io_underflow;

`ifdef ADDER_SB_FIRST_FAIL_EN
   sb_entry_t  ff_entry;
   sb_result_t ff_rsp;

   // First mismatch after reset is latched and held.
   always_ff @(posedge clock) begin
      if (reset) begin
         io_ff_valid <= 1'b0;
         ff_entry    <= '0;
         ff_rsp      <= '0;
      end else if (stg_valid && mismatch && !io_ff_valid) begin
         io_ff_valid <= 1'b1;
         ff_entry    <= stg_entry;
         ff_rsp      <= stg_rsp;
      end
   end

   assign io_ff_A    = WIDTH'(ff_entry.a);
   assign io_ff_B    = WIDTH'(ff_entry.b);
   assign io_ff_Cin  = ff_entry.cin;
   assign io_ff_Sum  = WIDTH'(ff_rsp.sum);
   assign io_ff_Cout = ff_rsp.cout;
`endif

endmodule

// File: tb/tb_adder_scoreboard.sv
// Directed bench for adder_scoreboard; a second instance with CNT_W=2 covers counter saturation.
module tb_adder_scoreboard;

   logic       clock = 1'b0;
   logic       reset;
   logic       stim_valid;
   logic [7:0] stim_a;
   logic [7:0] stim_b;
   logic       stim_cin;
   logic       rsp_valid;
   logic [7:0] rsp_sum;
   logic       rsp_cout;

   logic       ready;
   logic [2:0] pending;
   logic [15:0] pass_cnt;
   logic [15:0] fail_cnt;
   logic       underflow;
   logic       error;

   logic       s_ready;
   logic [2:0] s_pending;
   logic [1:0] s_pass;
   logic [1:0] s_fail;
   logic       s_underflow;
   logic       s_error;

`ifdef ADDER_SB_FIRST_FAIL_EN
   logic       ff_valid, ff_cin, ff_cout, s_ff_valid, s_ff_cin, s_ff_cout;
   logic [7:0] ff_a, ff_b, ff_sum, s_ff_a, s_ff_b, s_ff_sum;
`endif

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clock = ~clock;

   adder_scoreboard #(.WIDTH(8), .DEPTH(4), .CNT_W(16)) u_dut (
      .clock(clock), .reset(reset),
      .io_stim_valid(stim_valid), .io_stim_ready(ready),
      .io_stim_A(stim_a), .io_stim_B(stim_b), .io_stim_Cin(stim_cin),
      .io_rsp_valid(rsp_valid), .io_rsp_Sum(rsp_sum), .io_rsp_Cout(rsp_cout),
      .io_pending(pending), .io_pass_count(pass_cnt), .io_fail_count(fail_cnt),
      .io_underflow(underflow), .io_error(error)
`ifdef ADDER_SB_FIRST_FAIL_EN
     ,.io_ff_valid(ff_valid), .io_ff_A(ff_a), .io_ff_B(ff_b), .io_ff_Cin(ff_cin),
      .io_ff_Sum(ff_sum), .io_ff_Cout(ff_cout)
`endif
   );

   adder_scoreboard #(.WIDTH(8), .DEPTH(4), .CNT_W(2)) u_sat (
      .clock(clock), .reset(reset),
      .io_stim_valid(stim_valid), .io_stim_ready(s_ready),
      .io_stim_A(stim_a), .io_stim_B(stim_b), .io_stim_Cin(stim_cin),
      .io_rsp_valid(rsp_valid), .io_rsp_Sum(rsp_sum), .io_rsp_Cout(rsp_cout),
      .io_pending(s_pending), .io_pass_count(s_pass), .io_fail_count(s_fail),
      .io_underflow(s_underflow), .io_error(s_error)
`ifdef ADDER_SB_FIRST_FAIL_EN
     ,.io_ff_valid(s_ff_valid), .io_ff_A(s_ff_a), .io_ff_B(s_ff_b), .io_ff_Cin(s_ff_cin),
      .io_ff_Sum(s_ff_sum), .io_ff_Cout(s_ff_cout)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, let one rising edge sample them, return at the next falling edge.
   task automatic cyc(input logic sv, input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic rv, input logic [7:0] s, input logic co);
      stim_valid = sv; stim_a = a; stim_b = b; stim_cin = c;
      rsp_valid  = rv; rsp_sum = s; rsp_cout = co;
      @(negedge clock);
      stim_valid = 1'b0;
      rsp_valid  = 1'b0;
   endtask

   task automatic idle();
      cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic push(input logic [7:0] a, input logic [7:0] b, input logic c);
      cyc(1'b1, a, b, c, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic rsp(input logic [7:0] s, input logic co);
      cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, s, co);
   endtask

   function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input logic c);
      return {1'b0, a} + {1'b0, b} + {8'h00, c};
   endfunction

   logic [7:0] va [12];
   logic [7:0] vb [12];
   logic       vc [12];
   logic [8:0] ve;

   initial begin
      reset = 1'b1;
      stim_valid = 1'b0; stim_a = '0; stim_b = '0; stim_cin = 1'b0;
      rsp_valid  = 1'b0; rsp_sum = '0; rsp_cout = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      chk("rst_pending", 32'(pending), 32'd0);
      chk("rst_ready",   32'(ready),   32'd1);
      chk("rst_pass",    32'(pass_cnt), 32'd0);
      chk("rst_fail",    32'(fail_cnt), 32'd0);
      chk("rst_error",   32'(error),    32'd0);

      // Single correct transaction, response two cycles after push.
      push(8'h0F, 8'h01, 1'b0);
      chk("t1_pending_after_push", 32'(pending), 32'd1);
      idle();
      rsp(8'h10, 1'b0);
      chk("t1_pending_after_pop", 32'(pending), 32'd0);
      chk("t1_pass_not_yet", 32'(pass_cnt), 32'd0);
      idle();
      chk("t1_pass", 32'(pass_cnt), 32'd1);
      chk("t1_fail", 32'(fail_cnt), 32'd0);
      chk("t1_error", 32'(error), 32'd0);

      // Wrong carry-out on a carrying add.
      push(8'hFF, 8'h01, 1'b1);
      rsp(8'h01, 1'b0);
      idle();
      chk("t2_fail", 32'(fail_cnt), 32'd1);
      chk("t2_pass", 32'(pass_cnt), 32'd1);
      chk("t2_error", 32'(error), 32'd1);
`ifdef ADDER_SB_FIRST_FAIL_EN
      chk("t2_ff_valid", 32'(ff_valid), 32'd1);
      chk("t2_ff_a",     32'(ff_a),     32'hFF);
      chk("t2_ff_b",     32'(ff_b),     32'h01);
      chk("t2_ff_cin",   32'(ff_cin),   32'd1);
      chk("t2_ff_sum",   32'(ff_sum),   32'h01);
      chk("t2_ff_cout",  32'(ff_cout),  32'd0);
`endif

      // Fill the queue, try an overflowing push, then drain.
      push(8'h01, 8'h02, 1'b0);
      push(8'h10, 8'h20, 1'b1);
      push(8'h7F, 8'h01, 1'b0);
      push(8'h80, 8'h80, 1'b0);
      chk("t3_pending_full", 32'(pending), 32'd4);
      chk("t3_ready_low", 32'(ready), 32'd0);
      push(8'h55, 8'h00, 1'b0);
      chk("t3_pending_after_drop", 32'(pending), 32'd4);
      rsp(8'h03, 1'b0);
      rsp(8'h31, 1'b0);
      rsp(8'h80, 1'b0);
      rsp(8'h00, 1'b1);
      idle();
      chk("t3_pass", 32'(pass_cnt), 32'd5);
      chk("t3_fail", 32'(fail_cnt), 32'd1);
      chk("t3_pending_empty", 32'(pending), 32'd0);
`ifdef ADDER_SB_FIRST_FAIL_EN
      chk("t3_ff_held", 32'(ff_a), 32'hFF);
`endif

      // Steady state: two outstanding, push and correct pop every cycle.
      for (int k = 0; k < 12; k++) begin
         va[k] = 8'(k * 37 + 5);
         vb[k] = 8'(k * 29 + 200);
         vc[k] = k[0];
      end
      push(va[0], vb[0], vc[0]);
      push(va[1], vb[1], vc[1]);
      for (int k = 2; k < 12; k++) begin
         ve = model(va[k-2], vb[k-2], vc[k-2]);
         cyc(1'b1, va[k], vb[k], vc[k], 1'b1, ve[7:0], ve[8]);
         chk("t4_pending_steady", 32'(pending), 32'd2);
         chk("t4_pass_step", 32'(pass_cnt), 32'(5 + k - 2));
      end
      ve = model(va[10], vb[10], vc[10]);
      rsp(ve[7:0], ve[8]);
      ve = model(va[11], vb[11], vc[11]);
      rsp(ve[7:0], ve[8]);
      idle();
      chk("t4_pass", 32'(pass_cnt), 32'd17);
      chk("t4_fail", 32'(fail_cnt), 32'd1);

      // Response together with the first push into an empty queue.
      cyc(1'b1, 8'h33, 8'h44, 1'b0, 1'b1, 8'h77, 1'b0);
      idle();
      chk("t5_underflow", 32'(underflow), 32'd1);
      chk("t5_pending", 32'(pending), 32'd1);
      chk("t5_pass_same", 32'(pass_cnt), 32'd17);
      chk("t5_fail_same", 32'(fail_cnt), 32'd1);
      rsp(8'h77, 1'b0);
      idle();
      chk("t5_queued_entry_pass", 32'(pass_cnt), 32'd18);

      // Reset with three queued and a response in flight.
      push(8'h11, 8'h22, 1'b0);
      push(8'hF0, 8'h0F, 1'b1);
      push(8'hAA, 8'h55, 1'b0);
      chk("t6_pending_before", 32'(pending), 32'd3);
      reset = 1'b1;
      rsp(8'h33, 1'b0);
      reset = 1'b0;
      chk("t6_pending", 32'(pending), 32'd0);
      chk("t6_pass", 32'(pass_cnt), 32'd0);
      chk("t6_fail", 32'(fail_cnt), 32'd0);
      chk("t6_underflow", 32'(underflow), 32'd0);
      chk("t6_ready", 32'(ready), 32'd1);
      chk("t6_error", 32'(error), 32'd0);
      chk("t6_sat_pass", 32'(s_pass), 32'd0);
`ifdef ADDER_SB_FIRST_FAIL_EN
      chk("t6_ff_valid", 32'(ff_valid), 32'd0);
`endif
      idle();
      chk("t6_pass_still", 32'(pass_cnt), 32'd0);

      push(8'h01, 8'h01, 1'b0);
      rsp(8'h02, 1'b0);
      idle();
      chk("t6_pass_one", 32'(pass_cnt), 32'd1);
      chk("t6_sat_pass_one", 32'(s_pass), 32'd1);
      for (int k = 0; k < 4; k++) begin
         push(8'(k + 2), 8'h03, 1'b0);
         rsp(8'(k + 5), 1'b0);
      end
      idle();
      chk("t7_pass_five", 32'(pass_cnt), 32'd5);
      chk("t7_sat_pass", 32'(s_pass), 32'd3);
      chk("t7_sat_fail", 32'(s_fail), 32'd0);

      // Underflow alone drives the error flag.
      rsp(8'h00, 1'b0);
      idle();
      chk("t8_underflow", 32'(underflow), 32'd1);
      chk("t8_error", 32'(error), 32'd1);
      chk("t8_fail", 32'(fail_cnt), 32'd0);
      chk("t8_pass", 32'(pass_cnt), 32'd5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
